// File: rtl/edp_fm_ac_store.sv
// edp_fm_ac_store: fast-memory AC store for the EDP slices.
// BLOCKS x ACS words of WIDTH bits, one odd-parity bit per half-word.
// Reads are synchronous with write-through; a scrubber zeroes every word after reset.
// Optional feature macro: EDP_FM_PARITY_CHECK_EN enables the sticky read-parity checker.
//
// Handshake: there is no valid/ready flow control. Accesses are single-cycle
// commands sampled at every rising edge while fm_init_busy_h is low, and are
// ignored while it is high.
module edp_fm_ac_store #(
    parameter int WIDTH  = 36,
    parameter int BLOCKS = 8,
    parameter int ACS    = 16
) (
    input  logic                      clk_edp_00_h,
    input  logic                      reset_h,
    input  logic [$clog2(BLOCKS)-1:0] apr_fm_block_h,
    input  logic [$clog2(ACS)-1:0]    apr_fm_adr_h,
    input  logic                      con_fm_write_00to17_h,
    input  logic                      con_fm_write_18to35_h,
    input  logic [WIDTH-1:0]          ar_h,
    output logic [WIDTH-1:0]          fm_h,
    output logic                      edp_fm_parity_00to17_h,
    output logic                      edp_fm_parity_18to35_h,
    output logic                      fm_par_err_h,
    input  logic                      fm_par_err_clr_h,
    output logic                      fm_init_busy_h
);
    localparam int HW    = WIDTH / 2;
    localparam int DEPTH = BLOCKS * ACS;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;

    // Left half is the DEC bits 00-17 (upper packed bits), right half bits 18-35.
    logic [HW-1:0]   mem_l [DEPTH];
    logic [HW-1:0]   mem_r [DEPTH];
    logic            par_l [DEPTH];
    logic            par_r [DEPTH];

    logic [AW-1:0]   addr;
    logic            wr_l, wr_r;
    logic [AW-1:0]   wr_addr;
    logic [HW-1:0]   wdat_l, wdat_r;
    logic [HW-1:0]   rd_l, rd_r;
    logic            rd_pl, rd_pr;
    logic [HW-1:0]   fm_l_q, fm_r_q;

    assign addr = {apr_fm_block_h, apr_fm_adr_h};

    // State register: reset always restarts the scrub from word 0.
    always_ff @(posedge clk_edp_00_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state and array write port: scrubber owns the port during INIT.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wr_l           = 1'b0;
        wr_r           = 1'b0;
        wr_addr        = addr;
        wdat_l         = ar_h[WIDTH-1:HW];
        wdat_r         = ar_h[HW-1:0];
        fm_init_busy_h = 1'b0;
        case (state_q)
            S_INIT: begin
                fm_init_busy_h = 1'b1;
                wr_l           = 1'b1;
                wr_r           = 1'b1;
                wr_addr        = ptr_q;
                wdat_l         = '0;
                wdat_r         = '0;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            S_RUN: begin
                wr_l = con_fm_write_00to17_h;
                wr_r = con_fm_write_18to35_h;
            end
            default: begin
                state_d = S_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Array write: each enabled half stores its data with fresh odd parity.
    always_ff @(posedge clk_edp_00_h) begin
        if (wr_l) begin
            mem_l[wr_addr] <= wdat_l;
            par_l[wr_addr] <= ~^wdat_l;
        end
        if (wr_r) begin
            mem_r[wr_addr] <= wdat_r;
            par_r[wr_addr] <= ~^wdat_r;
        end
    end

    // Read mux: a half being written this cycle is forwarded, else the stored half.
    always_comb begin
        rd_l  = mem_l[addr];
        rd_pl = par_l[addr];
        rd_r  = mem_r[addr];
        rd_pr = par_r[addr];
        if (state_q == S_RUN && con_fm_write_00to17_h) begin
            rd_l  = ar_h[WIDTH-1:HW];
            rd_pl = ~^ar_h[WIDTH-1:HW];
        end
        if (state_q == S_RUN && con_fm_write_18to35_h) begin
            rd_r  = ar_h[HW-1:0];
            rd_pr = ~^ar_h[HW-1:0];
        end
    end

    // Read register: held at zero data / odd-parity ones while scrubbing.
    always_ff @(posedge clk_edp_00_h or posedge reset_h) begin
        if (reset_h) begin
            fm_l_q                 <= '0;
            fm_r_q                 <= '0;
            edp_fm_parity_00to17_h <= 1'b1;
            edp_fm_parity_18to35_h <= 1'b1;
        end else if (state_q == S_RUN) begin
            fm_l_q                 <= rd_l;
            fm_r_q                 <= rd_r;
            edp_fm_parity_00to17_h <= rd_pl;
            edp_fm_parity_18to35_h <= rd_pr;
        end
    end

    assign fm_h = {fm_l_q, fm_r_q};

`ifdef EDP_FM_PARITY_CHECK_EN
    logic bad_par;

    // The word being loaded into fm_h is checked so the error lands on the same edge.
    assign bad_par = (state_q == S_RUN) &&
                     ((^{rd_l, rd_pl}) != 1'b1 || (^{rd_r, rd_pr}) != 1'b1);

    // Sticky error latch; clear wins over a same-cycle set.
    always_ff @(posedge clk_edp_00_h or posedge reset_h) begin
        if (reset_h) begin
            fm_par_err_h <= 1'b0;
        end else if (fm_par_err_clr_h) begin
            fm_par_err_h <= 1'b0;
        end else if (bad_par) begin
            fm_par_err_h <= 1'b1;
        end
    end
`else
    logic unused_clr;

    assign unused_clr   = fm_par_err_clr_h;
    assign fm_par_err_h = 1'b0;
`endif

endmodule

// File: tb/tb_edp_fm_ac_store.sv
// tb_edp_fm_ac_store: directed table-driven bench for edp_fm_ac_store.
module tb_edp_fm_ac_store;
    logic        clk;
    logic        rst;
    logic [2:0]  blk;
    logic [3:0]  adr;
    logic        wl, wr;
    logic [35:0] ar;
    logic [35:0] fm;
    logic        pl, pr;
    logic        err;
    logic        clr;
    logic        busy;

    int total = 0;
    int passed = 0;
    int n;

`ifdef EDP_FM_PARITY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [2:0]  blk;
        logic [3:0]  adr;
        logic        wl;
        logic        wr;
        logic [35:0] data;
        logic [35:0] exp_fm;
        logic        exp_pl;
        logic        exp_pr;
    } vec_t;

    vec_t vecs [12];

    edp_fm_ac_store dut (
        .clk_edp_00_h           (clk),
        .reset_h                (rst),
        .apr_fm_block_h         (blk),
        .apr_fm_adr_h           (adr),
        .con_fm_write_00to17_h  (wl),
        .con_fm_write_18to35_h  (wr),
        .ar_h                   (ar),
        .fm_h                   (fm),
        .edp_fm_parity_00to17_h (pl),
        .edp_fm_parity_18to35_h (pr),
        .fm_par_err_h           (err),
        .fm_par_err_clr_h       (clr),
        .fm_init_busy_h         (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one access at the falling edge, then sample just after the rising edge.
    task automatic cycle(input logic [2:0] b, input logic [3:0] a, input logic l,
                         input logic r, input logic [35:0] d, input logic c);
        @(negedge clk);
        blk = b; adr = a; wl = l; wr = r; ar = d; clr = c;
        @(posedge clk);
        #1;
    endtask

    // Count rising edges until busy drops, bounded.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fm"},   fm,   36'o0);
        chk({tag, "_pl"},   {35'b0, pl},   36'o1);
        chk({tag, "_pr"},   {35'b0, pr},   36'o1);
        chk({tag, "_err"},  {35'b0, err},  36'o0);
        chk({tag, "_busy"}, {35'b0, busy}, 36'o1);
    endtask

    initial begin
        // Vectors: each row is one cycle; outputs are the registered read of that cycle.
        vecs[0]  = '{3'd7, 4'd15, 1'b0, 1'b0, 36'o0,            36'o0,            1'b1, 1'b1};
        vecs[1]  = '{3'd2, 4'd5,  1'b1, 1'b1, 36'o123456701234, 36'o123456701234, 1'b0, 1'b1};
        vecs[2]  = '{3'd2, 4'd5,  1'b0, 1'b0, 36'o0,            36'o123456701234, 1'b0, 1'b1};
        vecs[3]  = '{3'd2, 4'd5,  1'b1, 1'b0, 36'o777777000000, 36'o777777701234, 1'b1, 1'b1};
        vecs[4]  = '{3'd2, 4'd5,  1'b0, 1'b0, 36'o0,            36'o777777701234, 1'b1, 1'b1};
        vecs[5]  = '{3'd0, 4'd3,  1'b1, 1'b1, 36'o1,            36'o1,            1'b1, 1'b0};
        vecs[6]  = '{3'd0, 4'd3,  1'b0, 1'b0, 36'o0,            36'o1,            1'b1, 1'b0};
        vecs[7]  = '{3'd0, 4'd3,  1'b0, 1'b1, 36'o777777000003, 36'o000000000003, 1'b1, 1'b1};
        vecs[8]  = '{3'd1, 4'd0,  1'b1, 1'b1, 36'o000001000001, 36'o000001000001, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 4'd5,  1'b0, 1'b0, 36'o0,            36'o777777701234, 1'b1, 1'b1};
        vecs[10] = '{3'd7, 4'd15, 1'b0, 1'b0, 36'o555555555555, 36'o0,            1'b1, 1'b1};
        vecs[11] = '{3'd1, 4'd0,  1'b0, 1'b0, 36'o0,            36'o000001000001, 1'b0, 1'b0};

        blk = '0; adr = '0; wl = 1'b0; wr = 1'b0; ar = '0; clr = 1'b0;
        rst = 1'b0;

        // Reset values appear asynchronously, before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        chk("init_len", 36'(n), 36'd128);
        chk("init_done_busy", {35'b0, busy}, 36'o0);

        // Table
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].blk, vecs[i].adr, vecs[i].wl, vecs[i].wr, vecs[i].data, 1'b0);
            chk($sformatf("v%0d_fm", i),  fm, vecs[i].exp_fm);
            chk($sformatf("v%0d_pl", i),  {35'b0, pl}, {35'b0, vecs[i].exp_pl});
            chk($sformatf("v%0d_pr", i),  {35'b0, pr}, {35'b0, vecs[i].exp_pr});
            chk($sformatf("v%0d_err", i), {35'b0, err}, 36'o0);
        end

        // Corrupt one stored bit of blk2/ac5 (index 37); stored parity stays 1.
        @(negedge clk);
        wl = 1'b0; wr = 1'b0;
        dut.mem_l[37] = dut.mem_l[37] ^ 18'o000001;
        cycle(3'd2, 4'd5, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("bad_fm",  fm, 36'o777776701234);
        chk("bad_err", {35'b0, err}, {35'b0, CHK});
        cycle(3'd0, 4'd3, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("sticky_err", {35'b0, err}, {35'b0, CHK});
        cycle(3'd2, 4'd5, 1'b0, 1'b0, 36'o0, 1'b1);
        chk("clr_prio_err", {35'b0, err}, 36'o0);
        cycle(3'd0, 4'd3, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("clr_stays_err", {35'b0, err}, 36'o0);
        cycle(3'd2, 4'd5, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("reset_err_pre", {35'b0, err}, {35'b0, CHK});

        // Reset during a RUN write: outputs drop at once, write is lost.
        @(negedge clk);
        blk = 3'd4; adr = 4'd4; wl = 1'b1; wr = 1'b1; ar = 36'o555555555555; clr = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_run");
        @(negedge clk);
        wl = 1'b0; wr = 1'b0;
        rst = 1'b0;
        wait_init(n);
        chk("rerun_init_len", 36'(n), 36'd128);
        cycle(3'd4, 4'd4, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("lost_wr_fm", fm, 36'o0);
        chk("lost_wr_pl", {35'b0, pl}, 36'o1);
        chk("lost_wr_pr", {35'b0, pr}, 36'o1);

        // Reset at INIT cycle 60: scrub restarts and again takes 128 cycles.
        cycle(3'd1, 4'd0, 1'b1, 1'b1, 36'o000007000007, 1'b0);
        chk("pre_init_fm", fm, 36'o000007000007);
        @(negedge clk);
        wl = 1'b0; wr = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_pre");
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("mid_init_busy", {35'b0, busy}, 36'o1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_init");
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        chk("restart_init_len", 36'(n), 36'd128);
        cycle(3'd1, 4'd0, 1'b0, 1'b0, 36'o0, 1'b0);
        chk("scrubbed_fm", fm, 36'o0);
        chk("scrubbed_pl", {35'b0, pl}, 36'o1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
